// File: rtl/n64_pi_master.sv
// N64 PI cartridge-bus initiator: turns host burst requests into ALE/AD/READ_N/WRITE_N cycles.
// Latency: T_ALE*2 + T_SETUP + T_STROBE to the first word, then T_RECOVER + T_STROBE per word.
// Backpressure: req_ready only in IDLE; write stalls (strobes high) until wr_valid; reads cannot stall.
// Write handshake: wr_data/wr_valid are captured on the edge ending the last SETUP/RECOVER
// cycle, and wr_ready then pulses for one cycle to tell the host to present the next word.
module n64_pi_master #(
  parameter int T_ALE     = 4,
  parameter int T_SETUP   = 8,
  parameter int T_STROBE  = 8,
  parameter int T_RECOVER = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_words,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] pi_ad_out,
  output logic        pi_ad_oe,
  input  logic [15:0] pi_ad_in,
  output logic        pi_ale_h,
  output logic        pi_ale_l,
  output logic        pi_read_n,
  output logic        pi_write_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_SETUP, S_STROBE, S_RECOVER
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] addr, addr_n;
  logic [8:0]  left, left_n;
  logic        is_write, is_write_n;
  logic        capture, sample, fin;

  logic [15:0] ad_out_n, rd_data_n;
  logic        ad_oe_n, ale_h_n, ale_l_n, read_n_n, write_n_n;

  // Next-state, burst bookkeeping and next values of the registered pins
  always_comb begin
    state_n    = state;
    cnt_n      = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
    addr_n     = addr;
    left_n     = left;
    is_write_n = is_write;
    capture    = 1'b0;
    sample     = 1'b0;
    fin        = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_n     = req_addr & ~32'd1;
          left_n     = {1'b0, req_words} + 9'd1;
          is_write_n = req_write;
          state_n    = S_ADDR_HI;
          cnt_n      = 8'(T_ALE - 1);
        end
      end
      S_ADDR_HI: begin
        if (cnt == 8'd0) begin
          state_n = S_ADDR_LO;
          cnt_n   = 8'(T_ALE - 1);
        end
      end
      S_ADDR_LO: begin
        if (cnt == 8'd0) begin
          state_n = S_SETUP;
          cnt_n   = 8'(T_SETUP - 1);
        end
      end
      S_SETUP: begin
        // a write with no word available parks here with cnt held at 0
        if (cnt == 8'd0 && (!is_write || wr_valid)) begin
          state_n = S_STROBE;
          cnt_n   = 8'(T_STROBE - 1);
          capture = is_write;
        end
      end
      S_STROBE: begin
        if (cnt == 8'd0) begin
          state_n = S_RECOVER;
          cnt_n   = 8'(T_RECOVER - 1);
          sample  = !is_write;
          addr_n  = addr + 32'd2;
          left_n  = left - 9'd1;
        end
      end
      S_RECOVER: begin
        if (cnt == 8'd0) begin
          if (left == 9'd0) begin
            state_n = S_IDLE;
            fin     = 1'b1;
          end else if (addr[8:0] == 9'd0) begin
            // crossed a 512-byte PI block: the cart needs a fresh address
            state_n = S_ADDR_HI;
            cnt_n   = 8'(T_ALE - 1);
          end else if (!is_write || wr_valid) begin
            state_n = S_STROBE;
            cnt_n   = 8'(T_STROBE - 1);
            capture = is_write;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    ale_h_n   = (state_n == S_ADDR_HI);
    ale_l_n   = (state_n == S_ADDR_HI) || (state_n == S_ADDR_LO);
    read_n_n  = !((state_n == S_STROBE) && !is_write_n);
    write_n_n = !((state_n == S_STROBE) && is_write_n);
    // AD is only driven for address phases and for the whole data part of a write
    ad_oe_n   = ale_l_n ||
                (is_write_n && ((state_n == S_SETUP) || (state_n == S_STROBE) ||
                                (state_n == S_RECOVER)));

    ad_out_n = pi_ad_out;
    if (state_n == S_IDLE)         ad_out_n = 16'h0000;
    else if (state_n == S_ADDR_HI) ad_out_n = addr_n[31:16];
    else if (state_n == S_ADDR_LO) ad_out_n = addr_n[15:0];
    else if (capture)              ad_out_n = wr_data;

    rd_data_n = sample ? pi_ad_in : rd_data;
  end

  // State, counters and every output pin are registered; reset idles the bus at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      addr       <= 32'd0;
      left       <= 9'd0;
      is_write   <= 1'b0;
      req_ready  <= 1'b0;
      wr_ready   <= 1'b0;
      rd_data    <= 16'h0000;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pi_ad_out  <= 16'h0000;
      pi_ad_oe   <= 1'b0;
      pi_ale_h   <= 1'b0;
      pi_ale_l   <= 1'b0;
      pi_read_n  <= 1'b1;
      pi_write_n <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      addr       <= addr_n;
      left       <= left_n;
      is_write   <= is_write_n;
      req_ready  <= (state_n == S_IDLE);
      wr_ready   <= capture;
      rd_data    <= rd_data_n;
      rd_valid   <= sample;
      busy       <= (state_n != S_IDLE);
      done       <= fin;
      pi_ad_out  <= ad_out_n;
      pi_ad_oe   <= ad_oe_n;
      pi_ale_h   <= ale_h_n;
      pi_ale_l   <= ale_l_n;
      pi_read_n  <= read_n_n;
      pi_write_n <= write_n_n;
    end
  end

endmodule

// File: tb/tb_n64_pi_master.sv
// Bench for n64_pi_master: directed bursts against a small cartridge model.
// A forked monitor checks read words, write words and address phases against queues.
// Protocol rules (strobe width, ALE/strobe overlap, AD direction) are tallied per test.
module tb_n64_pi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_words;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, busy, done;
  logic [15:0] pi_ad_out, pi_ad_in;
  logic        pi_ad_oe, pi_ale_h, pi_ale_l, pi_read_n, pi_write_n;

  always #5 clk = ~clk;

  n64_pi_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_words(req_words),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .pi_ad_out(pi_ad_out), .pi_ad_oe(pi_ad_oe), .pi_ad_in(pi_ad_in),
    .pi_ale_h(pi_ale_h), .pi_ale_l(pi_ale_l),
    .pi_read_n(pi_read_n), .pi_write_n(pi_write_n)
  );

  int compared = 0;
  int mismatched = 0;

  logic [15:0] exp_rd[$];
  logic [31:0] exp_addr[$];
  logic [15:0] exp_wr[$];

  // cartridge model state
  logic        cart_mode = 1'b0;   // 0: constant 0x8037, 1: returns addr[15:0]
  logic [31:0] cart_addr = 32'd0;
  logic [15:0] c_hi = 16'd0, c_lo = 16'd0, wdat = 16'd0;
  logic        prev_ale_l = 1'b0;
  logic        wr_burst = 1'b0;
  int rlow = 0, wlow = 0;
  int rd_pulses = 0, wr_pulses = 0, done_cnt = 0, wr_rdy_cnt = 0, viol = 0;

  assign pi_ad_in = cart_mode ? cart_addr[15:0] : 16'h8037;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got unexpected event, required none", name);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] n);
    int t;
    t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_words = n;
    while (!req_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) fail_now("req_ready timeout");
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) break;
    end
    if (!done) fail_now("done timeout");
  endtask

  task automatic wait_wr_ready(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wr_ready && t < 2000);
    if (!wr_ready) fail_now(name);
  endtask

  task automatic end_test(input string name, input int viol0);
    repeat (3) @(negedge clk);
    chk({name, " rd queue empty"},   exp_rd.size(),   0);
    chk({name, " addr queue empty"}, exp_addr.size(), 0);
    chk({name, " wr queue empty"},   exp_wr.size(),   0);
    chk({name, " protocol faults"},  viol - viol0,    0);
  endtask

  initial begin
    int cyc, v0, r0, w0, d0, k0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_words = 8'd0; wr_data = 16'd0; wr_valid = 1'b0;

    // monitor / cartridge model / scoreboard
    fork
      forever begin
        @(negedge clk);
        if (pi_ale_h && pi_ale_l) c_hi = pi_ad_out;
        else if (pi_ale_l)        c_lo = pi_ad_out;
        if (prev_ale_l && !pi_ale_l && rst_n) begin
          cart_addr = {c_hi, c_lo};
          if (exp_addr.size() == 0) fail_now("address phase");
          else chk("address phase", cart_addr, exp_addr.pop_front());
        end
        if (!pi_read_n) begin
          if (rlow == 0) rd_pulses++;
          rlow++;
        end else begin
          if (rlow != 0) begin
            if (rst_n && rlow != 8) viol++;
            cart_addr = cart_addr + 32'd2;
          end
          rlow = 0;
        end
        if (!pi_write_n) begin
          if (wlow == 0) wr_pulses++;
          wlow++;
          wdat = pi_ad_out;
        end else begin
          if (wlow != 0) begin
            if (rst_n && wlow != 8) viol++;
            if (exp_wr.size() == 0) fail_now("write word");
            else chk("write word", wdat, exp_wr.pop_front());
          end
          wlow = 0;
        end
        if ((pi_ale_h || pi_ale_l) && (!pi_read_n || !pi_write_n)) viol++;
        if (pi_ad_oe && !pi_read_n) viol++;
        if (pi_ale_h && !pi_ale_l) viol++;
        if (wr_burst && busy && !pi_ad_oe) viol++;
        if (rd_valid) begin
          if (exp_rd.size() == 0) fail_now("read word");
          else chk("read word", rd_data, exp_rd.pop_front());
        end
        if (done) done_cnt++;
        if (wr_ready) wr_rdy_cnt++;
        prev_ale_l = pi_ale_l;
      end
    join_none

    // reset values
    #12;
    chk("reset ale_h", pi_ale_h, 0);
    chk("reset ale_l", pi_ale_l, 0);
    chk("reset read_n", pi_read_n, 1);
    chk("reset write_n", pi_write_n, 1);
    chk("reset ad_oe", pi_ad_oe, 0);
    chk("reset ad_out", pi_ad_out, 0);
    chk("reset busy/done/rd_valid/wr_ready", {busy, done, rd_valid, wr_ready}, 0);
    chk("reset rd_data", rd_data, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("req_ready before first edge", req_ready, 0);
    @(posedge clk); #1 chk("req_ready after first edge", req_ready, 1);

    // 1: single read, constant cart word
    v0 = viol; r0 = rd_pulses; d0 = done_cnt;
    cart_mode = 1'b0;
    exp_addr.push_back(32'h1000_0000);
    exp_rd.push_back(16'h8037);
    issue(1'b0, 32'h1000_0000, 8'd0);
    wait_done(cyc);
    chk("t1 burst cycles", cyc, 28);
    chk("t1 busy low at done", busy, 0);
    chk("t1 req_ready at done", req_ready, 1);
    @(negedge clk) chk("t1 done is one cycle", done, 0);
    end_test("t1", v0);
    chk("t1 read pulses", rd_pulses - r0, 1);
    chk("t1 done pulses", done_cnt - d0, 1);

    // 2: four words inside one block
    v0 = viol; r0 = rd_pulses;
    cart_mode = 1'b1;
    exp_addr.push_back(32'h1000_0040);
    exp_rd.push_back(16'h0040); exp_rd.push_back(16'h0042);
    exp_rd.push_back(16'h0044); exp_rd.push_back(16'h0046);
    issue(1'b0, 32'h1000_0040, 8'd3);
    wait_done(cyc);
    chk("t2 burst cycles", cyc, 16 + 4 * 8 + 4 * 4 + 3 * 0);
    end_test("t2", v0);
    chk("t2 read pulses", rd_pulses - r0, 4);

    // 3: burst crossing a 512-byte block re-issues the address
    v0 = viol; r0 = rd_pulses;
    exp_addr.push_back(32'h1000_01FC); exp_addr.push_back(32'h1000_0200);
    exp_rd.push_back(16'h01FC); exp_rd.push_back(16'h01FE);
    exp_rd.push_back(16'h0200); exp_rd.push_back(16'h0202);
    issue(1'b0, 32'h1000_01FC, 8'd3);
    wait_done(cyc);
    end_test("t3", v0);
    chk("t3 read pulses", rd_pulses - r0, 4);

    // 4: two-word write with a 20-cycle stall on the second word
    v0 = viol; w0 = wr_pulses; k0 = wr_rdy_cnt;
    wr_burst = 1'b1;
    exp_addr.push_back(32'h1000_0000);
    exp_wr.push_back(16'hA5A5); exp_wr.push_back(16'h5A5A);
    wr_data = 16'hA5A5; wr_valid = 1'b1;
    fork
      begin
        issue(1'b1, 32'h1000_0000, 8'd1);
        wait_done(cyc);
      end
      begin
        wait_wr_ready("t4 first wr_ready timeout");
        wr_valid = 1'b0; wr_data = 16'h0000;
        repeat (20) @(negedge clk);
        chk("t4 no strobe during stall", wr_pulses - w0, 1);
        chk("t4 write_n high in stall", pi_write_n, 1);
        wr_data = 16'h5A5A; wr_valid = 1'b1;
        wait_wr_ready("t4 second wr_ready timeout");
        wr_valid = 1'b0;
      end
    join
    wr_burst = 1'b0;
    end_test("t4", v0);
    chk("t4 write pulses", wr_pulses - w0, 2);
    chk("t4 wr_ready pulses", wr_rdy_cnt - k0, 2);

    // 5: reset in the middle of a read strobe
    v0 = viol; d0 = done_cnt;
    exp_addr.push_back(32'h1000_0080);
    issue(1'b0, 32'h1000_0080, 8'd2);
    begin
      int t;
      t = 0;
      while (pi_read_n && t < 1000) begin @(negedge clk); t++; end
      if (pi_read_n) fail_now("t5 strobe timeout");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5 read_n released", pi_read_n, 1);
    chk("t5 ale low", {pi_ale_h, pi_ale_l}, 0);
    chk("t5 ad_oe low", pi_ad_oe, 0);
    chk("t5 busy low", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5 req_ready after release", req_ready, 1);
    chk("t5 no done", done_cnt - d0, 0);
    end_test("t5", v0);

    // 6: second request while busy waits for done; bit 0 of its address is dropped
    v0 = viol; d0 = done_cnt;
    exp_addr.push_back(32'h1000_0100); exp_addr.push_back(32'h1000_0300);
    exp_rd.push_back(16'h0100);
    exp_rd.push_back(16'h0300); exp_rd.push_back(16'h0302);
    issue(1'b0, 32'h1000_0100, 8'd0);
    issue(1'b0, 32'h1000_0301, 8'd1);
    chk("t6 second accepted after first done", done_cnt - d0, 1);
    wait_done(cyc);
    end_test("t6", v0);
    chk("t6 done pulses", done_cnt - d0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
